lisnoc_router_input_stage: RTL and testbench
============================================

LISNOC_ROUTER_INPUT_STAGE -- requirements
Module: lisnoc_router_input_stage

Interface
REQ-001 SHALL have parameter flit_data_width, default 32, flit payload width.
REQ-002 SHALL have parameter flit_type_width, default 2, flit type field width; flit_width = flit_data_width+flit_type_width.
REQ-003 SHALL have parameter ports, default 5, number of router output ports.
REQ-004 SHALL have parameter fifo_depth, default 4, buffer entries; power of two, at least 2.
REQ-005 SHALL have parameter ph_dest_width, default 5, header destination field width at flit data bits [flit_data_width-1 -: ph_dest_width].
REQ-006 SHALL have parameter destinations, default 32, routing table entries.
REQ-007 SHALL have parameter routes, width ports*destinations, default 0, one-hot output mask per destination; entry d is bits [ports*(d+1)-1 : ports*d].
REQ-008 SHALL have input clk, 1, clock; reset rst, synchronous, active-high.
REQ-009 SHALL have input in_flit, flit_width, link flit with type in the top flit_type_width bits.
REQ-010 SHALL have input in_valid, 1, link flit valid.
REQ-011 SHALL have output in_ready, 1, buffer can accept.
REQ-012 SHALL have output out_flit, flit_width, buffer head flit, broadcast to all output arbiters.
REQ-013 SHALL have output out_request, ports, one-hot request to the output arbiters.
REQ-014 SHALL have input read_i, ports, read strobes from the output arbiters.
REQ-015 SHALL have output err_o, 1, routing error pulse; present only with LISNOC_ROUTER_INPUT_ERR_EN.
REQ-016 SHALL have output err_cnt_o, 8, saturating dropped-packet count; present only with LISNOC_ROUTER_INPUT_ERR_EN.

Function
REQ-017 SHALL decode types as payload 2'b00, header 2'b01, last 2'b10, single 2'b11.
REQ-018 SHALL set in_ready = count < fifo_depth and push on in_valid && in_ready; simultaneous push and pop SHALL leave count unchanged.
REQ-019 SHALL pop one flit when the FIFO is non-empty and |(read_i & out_request) is true; read_i bits outside out_request SHALL be ignored.
REQ-020 SHALL implement FSM IDLE/ACTIVE/DRAIN; reset state IDLE.
REQ-021 In IDLE with a header/single flit at head, SHALL register route_q = routes entry[dest] and enter ACTIVE next cycle.
REQ-022 In ACTIVE, out_request SHALL equal route_q while the FIFO is non-empty and 0 while empty; route_q SHALL remain stable for the whole packet.
REQ-023 Popping a last/single flit in ACTIVE SHALL return the FSM to IDLE with out_request 0 on the next cycle, giving one bubble cycle between packets.
REQ-024 Latency: a header pushed at edge N SHALL appear on out_flit in cycle N+1 and raise out_request in cycle N+2.
REQ-025 A payload/last flit at head in IDLE is a protocol error: it SHALL be popped without request, one per cycle.
REQ-026 A header with dest >= destinations, or an all-zero route entry, SHALL enter DRAIN. DRAIN SHALL pop flits without request until last/single is popped, then return to IDLE. A single flit SHALL be dropped in one cycle.
REQ-027 out_flit SHALL always present the head entry; its value is don't-care when the FIFO is empty.

Reset
REQ-028 Reset SHALL clear count and pointers, set FSM IDLE and route_q 0, force out_request 0, make in_ready 1 from the first post-reset cycle, and clear err_o/err_cnt_o.
REQ-029 Reset mid-packet SHALL discard all buffered flits.

Configuration
REQ-030 With LISNOC_ROUTER_INPUT_ERR_EN defined, err_o SHALL pulse one cycle per REQ-025 discarded flit or REQ-026 drop. err_cnt_o SHALL increment per event and saturate at 255.
REQ-031 Without the macro, err_o and err_cnt_o and their logic SHALL be absent; drop behaviour SHALL be unchanged.

Structure
REQ-032 Flit type constants SHALL come from lisnoc_def.vh; the state encoding and dest-field helper SHALL live in package lisnoc_router_pkg.
REQ-033 The buffer SHALL be sub-module lisnoc_router_input_fifo (push/pop/full/empty/head); routing and the FSM SHALL stay in this module.

Verification
REQ-034 Header dest 3 with routes[3] = 5'b00100, followed by 2 payload and a last, read_i = 5'b00100 continuously -> out_request 5'b00100 from cycle N+2, 4 pops, out_request 0 after the last.
REQ-035 5 flits offered at fifo_depth 4 with read_i = 0 -> in_ready low after 4 pushes; one pop -> in_ready high the next cycle.
REQ-036 Two back-to-back single flits to ports 1 and 4 -> requests 5'b00010 then 5'b10000, separated by exactly one zero cycle.
REQ-037 Header dest 40 with destinations 32, ERR_EN defined -> packet drained, out_request 0 throughout, err_o one pulse, err_cnt_o 1.
REQ-038 Packet in flight with a FIFO underflow gap -> out_request drops to 0 during the gap and returns to the same mask; rst mid-packet -> count 0, IDLE, out_request 0.

Source files
------------

// File: rtl/lisnoc_router_pkg.sv
// Shared definitions for the LISNoC router input stage: flit type codes
// (same values as the LISNoC lisnoc_def.vh flit type definitions), the input
// FSM state encoding and the header destination field helper.
package lisnoc_router_pkg;

    localparam logic [1:0] FLIT_TYPE_PAYLOAD = 2'b00;
    localparam logic [1:0] FLIT_TYPE_HEADER  = 2'b01;
    localparam logic [1:0] FLIT_TYPE_LAST    = 2'b10;
    localparam logic [1:0] FLIT_TYPE_SINGLE  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    // Destination field sits in the top dest_w bits of the flit payload.
    function automatic logic [31:0] get_dest(input logic [255:0] data,
                                             input int data_w,
                                             input int dest_w);
        return 32'(data >> (data_w - dest_w)) & ((32'd1 << dest_w) - 32'd1);
    endfunction

endpackage

// File: rtl/lisnoc_router_input_fifo.sv
// Input buffer of the router input stage: power-of-two ring buffer with
// head-of-queue output. Pushes while full and pops while empty are ignored.
module lisnoc_router_input_fifo #(
    parameter int width = 34,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] din,
    output logic [width-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int aw = $clog2(depth);

    logic [width-1:0] mem_q [depth];
    logic [aw-1:0]    wr_ptr_q, wr_ptr_d;
    logic [aw-1:0]    rd_ptr_q, rd_ptr_d;
    logic [aw:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (aw+1)'(depth));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q + aw'(do_push);
        rd_ptr_d = rd_ptr_q + aw'(do_pop);
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (aw+1)'(1);
            2'b01:   count_d = count_q - (aw+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage write; contents need no reset since occupancy gates them.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/lisnoc_router_input_stage.sv
// LISNoC router input stage: buffers link flits, routes each packet from its
// header destination through the static routes table and requests exactly one
// output port for the whole packet. Misrouted packets and stray flits are
// discarded. Optional error reporting (err_o, err_cnt_o) is built when
// LISNOC_ROUTER_INPUT_ERR_EN is defined.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for a header/single at head; look up the route
// ST_ACTIVE | packet routed; request route_q while flits are buffered
// ST_DRAIN  | unroutable packet; pop flits until its last flit
module lisnoc_router_input_stage
    import lisnoc_router_pkg::*;
#(
    parameter int flit_data_width = 32,
    parameter int flit_type_width = 2,
    parameter int ports           = 5,
    parameter int fifo_depth      = 4,
    parameter int ph_dest_width   = 5,
    parameter int destinations    = 32,
    parameter logic [ports*destinations-1:0] routes = '0
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [flit_data_width+flit_type_width-1:0] in_flit,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    output logic [flit_data_width+flit_type_width-1:0] out_flit,
    output logic [ports-1:0]                           out_request,
    input  logic [ports-1:0]                           read_i
`ifdef LISNOC_ROUTER_INPUT_ERR_EN
    ,
    output logic                                       err_o,
    output logic [7:0]                                 err_cnt_o
`else
    // no error reporting ports in this build
`endif
);

    localparam int flit_width = flit_data_width + flit_type_width;

    state_t                     state_q, state_d;
    logic [ports-1:0]           route_q, route_d;
    logic [ports-1:0]           route_lookup;
    logic [flit_type_width-1:0] head_type;
    logic [flit_data_width-1:0] head_data;
    logic [31:0]                dest;
    logic                       full, empty;
    logic                       is_start, is_end;
    logic                       req_pop, drop_pop, pop;

    lisnoc_router_input_fifo #(
        .width (flit_width),
        .depth (fifo_depth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && in_ready),
        .pop   (pop),
        .din   (in_flit),
        .head  (out_flit),
        .full  (full),
        .empty (empty)
    );

    assign in_ready  = !full;
    assign head_type = out_flit[flit_width-1 -: flit_type_width];
    assign head_data = out_flit[flit_data_width-1:0];
    assign dest      = get_dest(256'(head_data), flit_data_width, ph_dest_width);
    assign is_start  = (head_type == flit_type_width'(FLIT_TYPE_HEADER)) ||
                       (head_type == flit_type_width'(FLIT_TYPE_SINGLE));
    assign is_end    = (head_type == flit_type_width'(FLIT_TYPE_LAST)) ||
                       (head_type == flit_type_width'(FLIT_TYPE_SINGLE));

    // Request only while a routed packet has a flit waiting at head.
    assign out_request = (state_q == ST_ACTIVE && !empty) ? route_q : '0;
    assign req_pop     = |(read_i & out_request);
    assign pop         = req_pop || drop_pop;

    // Route table lookup; out-of-range destinations leave an all-zero mask.
    always_comb begin
        route_lookup = '0;
        for (int d = 0; d < destinations; d++) begin
            if (dest == 32'(d)) route_lookup = routes[ports*d +: ports];
        end
    end

    // Next state, route capture and discard decisions.
    always_comb begin
        state_d  = state_q;
        route_d  = route_q;
        drop_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    if (!is_start) begin
                        drop_pop = 1'b1;
                    end else if (|route_lookup) begin
                        route_d = route_lookup;
                        state_d = ST_ACTIVE;
                    end else begin
                        drop_pop = 1'b1;
                        if (!is_end) state_d = ST_DRAIN;
                    end
                end
            end
            ST_ACTIVE: begin
                if (req_pop && is_end) state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (!empty) begin
                    drop_pop = 1'b1;
                    if (is_end) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and route registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            route_q <= '0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end

`ifdef LISNOC_ROUTER_INPUT_ERR_EN
    logic       err_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    // One event per stray flit or per unroutable packet, both seen in IDLE.
    always_comb begin
        err_d     = drop_pop && (state_q == ST_IDLE);
        err_cnt_d = err_cnt_q;
        if (err_d && err_cnt_q != 8'hff) err_cnt_d = err_cnt_q + 8'd1;
    end

    // Error pulse and saturating counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;
`else
    // drops still happen; they are simply not reported
`endif

endmodule

// File: tb/tb_lisnoc_router_input_stage.sv
// Directed bench for lisnoc_router_input_stage. Inputs change and outputs are
// sampled on the falling clock edge. Error reporting checks are compiled in
// when LISNOC_ROUTER_INPUT_ERR_EN is defined.
module tb_lisnoc_router_input_stage;

    localparam int FDW = 32;
    localparam int FTW = 2;
    localparam int FW  = FDW + FTW;
    localparam int P   = 5;
    localparam int D   = 32;
    // dest 1 -> port 1, dest 3 -> port 2, dest 4 -> port 4, dest 7 -> no route
    localparam logic [P*D-1:0] ROUTES = (160'h02 << 5) | (160'h04 << 15) | (160'h10 << 20);

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] in_flit;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] out_flit;
    logic [P-1:0]  out_request;
    logic [P-1:0]  read_i;
`ifdef LISNOC_ROUTER_INPUT_ERR_EN
    logic          err_o;
    logic [7:0]    err_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    lisnoc_router_input_stage #(
        .flit_data_width (FDW),
        .flit_type_width (FTW),
        .ports           (P),
        .fifo_depth      (4),
        .ph_dest_width   (6),
        .destinations    (D),
        .routes          (ROUTES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_flit     (in_flit),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_flit    (out_flit),
        .out_request (out_request),
        .read_i      (read_i)
`ifdef LISNOC_ROUTER_INPUT_ERR_EN
        ,
        .err_o       (err_o),
        .err_cnt_o   (err_cnt_o)
`endif
    );

    function automatic logic [FW-1:0] hdr(input int d);
        return {2'b01, 6'(d), 26'h0000155};
    endfunction
    function automatic logic [FW-1:0] single(input int d);
        return {2'b11, 6'(d), 26'h00002aa};
    endfunction
    function automatic logic [FW-1:0] pay(input int n);
        return {2'b00, 32'(n)};
    endfunction
    function automatic logic [FW-1:0] last(input int n);
        return {2'b10, 32'(n)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        logic [FW-1:0] seq [3];
        rst = 1'b1; in_valid = 1'b0; in_flit = '0; read_i = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_ready", in_ready, 1);
        check("rst_req", out_request, 0);
`ifdef LISNOC_ROUTER_INPUT_ERR_EN
        check("rst_errcnt", err_cnt_o, 0);
`endif

        // header dest 3, two payloads, last; port 2 reads continuously
        read_i = 5'b00100; in_flit = hdr(3); in_valid = 1'b1; tick();
        check("t1_flit_n1", out_flit, hdr(3));
        check("t1_req_n1", out_request, 0);
        in_flit = pay(1); tick();
        check("t1_req_n2", out_request, 5'b00100);
        check("t1_flit_n2", out_flit, hdr(3));
        in_flit = pay(2); tick();
        check("t1_flit_p1", out_flit, pay(1));
        in_flit = last(3); tick();
        check("t1_flit_p2", out_flit, pay(2));
        in_valid = 1'b0; tick();
        check("t1_flit_last", out_flit, last(3));
        check("t1_req_last", out_request, 5'b00100);
        tick();
        check("t1_req_end", out_request, 0);

        // fill to depth with no reads, then one pop frees a slot
        read_i = '0; in_valid = 1'b1; in_flit = hdr(3); tick();
        check("t2_ready1", in_ready, 1);
        in_flit = pay(11); tick();
        check("t2_ready2", in_ready, 1);
        in_flit = pay(12); tick();
        check("t2_ready3", in_ready, 1);
        in_flit = pay(13); tick();
        check("t2_full", in_ready, 0);
        in_flit = last(14); read_i = 5'b00100; tick();
        check("t2_ready_again", in_ready, 1);
        check("t2_head_p11", out_flit, pay(11));
        tick();
        check("t2_pushpop_ready", in_ready, 1);
        check("t2_head_p12", out_flit, pay(12));
        in_valid = 1'b0; tick(); tick();
        check("t2_head_last", out_flit, last(14));
        check("t2_req_last", out_request, 5'b00100);
        tick();
        check("t2_req_end", out_request, 0);

        // back-to-back single flits to ports 1 and 4
        read_i = 5'b10010; in_flit = single(1); in_valid = 1'b1; tick();
        in_flit = single(4); tick();
        in_valid = 1'b0;
        check("t3_req_a", out_request, 5'b00010);
        tick();
        check("t3_bubble", out_request, 0);
        tick();
        check("t3_req_b", out_request, 5'b10000);
        tick();
        check("t3_req_end", out_request, 0);

        // unroutable destination 40 is drained without request
        read_i = 5'b11111;
        seq[0] = hdr(40); seq[1] = pay(21); seq[2] = last(22);
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 3);
            if (i < 3) in_flit = seq[i];
            tick();
            check("t4_drain_req", out_request, 0);
`ifdef LISNOC_ROUTER_INPUT_ERR_EN
            pulses = pulses + int'(err_o);
`endif
        end
        in_valid = 1'b0;
`ifdef LISNOC_ROUTER_INPUT_ERR_EN
        check("t4_err_pulses", pulses, 1);
        check("t4_errcnt", err_cnt_o, 1);
`endif
        in_flit = single(3); in_valid = 1'b1; tick();
        in_valid = 1'b0;
        check("t4_recover_idle", out_request, 0);
        tick();
        check("t4_recover_req", out_request, 5'b00100);
        tick();
        check("t4_recover_end", out_request, 0);

        // stray payload in IDLE is dropped, following single still routes
        in_flit = pay(30); in_valid = 1'b1; tick();
        in_flit = single(1); tick();
        in_valid = 1'b0;
        check("t4_stray_req0", out_request, 0);
        tick();
        check("t4_stray_req", out_request, 5'b00010);
`ifdef LISNOC_ROUTER_INPUT_ERR_EN
        check("t4_stray_errcnt", err_cnt_o, 2);
`endif
        tick();
        // single to destination with an all-zero route entry is dropped
        in_flit = single(7); in_valid = 1'b1; tick();
        in_flit = single(4); tick();
        in_valid = 1'b0;
        check("t4_zero_route_req0", out_request, 0);
        tick();
        check("t4_zero_route_next", out_request, 5'b10000);
`ifdef LISNOC_ROUTER_INPUT_ERR_EN
        check("t4_zero_route_errcnt", err_cnt_o, 3);
`endif
        tick();

        // underflow gap inside a packet, then reset mid-packet
        read_i = 5'b00100; in_flit = hdr(3); in_valid = 1'b1; tick();
        in_valid = 1'b0; tick();
        check("t5_req", out_request, 5'b00100);
        tick();
        check("t5_gap", out_request, 0);
        in_flit = pay(41); in_valid = 1'b1; tick();
        in_valid = 1'b0;
        check("t5_resume", out_request, 5'b00100);
        tick();
        check("t5_gap2", out_request, 0);
        read_i = '0; in_flit = pay(42); in_valid = 1'b1; tick(); tick();
        in_valid = 1'b0;
        check("t5_pre_rst", out_request, 5'b00100);
        rst = 1'b1; tick();
        rst = 1'b0;
        check("t5_rst_req", out_request, 0);
        check("t5_rst_ready", in_ready, 1);
`ifdef LISNOC_ROUTER_INPUT_ERR_EN
        check("t5_rst_errcnt", err_cnt_o, 0);
`endif
        read_i = 5'b10000; in_flit = single(4); in_valid = 1'b1; tick();
        in_valid = 1'b0;
        check("t5_post_rst_idle", out_request, 0);
        tick();
        check("t5_post_rst_req", out_request, 5'b10000);
        tick();
        check("t5_post_rst_end", out_request, 0);

`ifdef LISNOC_ROUTER_INPUT_ERR_EN
        // 260 stray payloads saturate the drop counter
        read_i = '0; in_flit = pay(50); in_valid = 1'b1;
        repeat (260) tick();
        in_valid = 1'b0; tick(); tick();
        check("t6_errcnt_sat", err_cnt_o, 255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
